// File: rtl/pc_ctrl_if.sv
// Fetch-stage PC control bundle: redirect/stall controls in, fetch address
// and return-stack status out.
interface pc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             EN;
    logic             BR_TAKEN;
    logic [WIDTH-1:0] BR_TARGET;
    logic             CALL;
    logic             RET;
    logic             TRAP;
    logic [WIDTH-1:0] PCOut;
    logic [WIDTH-1:0] PCPlus;
    logic [WIDTH-1:0] EPC;
    logic             RAS_EMPTY;
    logic             RAS_FULL;
    logic             RAS_UFL;

    // hazard unit / branch logic side
    modport master (
        output EN, BR_TAKEN, BR_TARGET, CALL, RET, TRAP,
        input  PCOut, PCPlus, EPC, RAS_EMPTY, RAS_FULL, RAS_UFL
    );

    // program counter side
    modport slave (
        input  EN, BR_TAKEN, BR_TARGET, CALL, RET, TRAP,
        output PCOut, PCPlus, EPC, RAS_EMPTY, RAS_FULL, RAS_UFL
    );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch-stage program counter with trap capture and a circular
// return-address stack. Next-PC priority: reset, trap, stall, return,
// call, branch, sequential.
module pc_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h00000000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h00000080,
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RST,
    pc_ctrl_if.slave  bus
);
    localparam int               PW    = $clog2(RAS_DEPTH);
    localparam int               CW    = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_ufl;
    logic [PW-1:0]    r_ptr;     // next free slot; top entry is r_ptr-1
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc_plus;
    logic [PW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_epc_next;
    logic             w_ufl_next;
    logic             w_push;
    logic             w_pop;
    logic             w_replace;

    assign w_pc_plus = r_pc + INC_W;
    assign w_top_idx = r_ptr - 1'b1;
    assign w_top     = r_ras[w_top_idx];
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == DEPTH_C);

    assign bus.PCOut     = r_pc;
    assign bus.PCPlus    = w_pc_plus;
    assign bus.EPC       = r_epc;
    assign bus.RAS_EMPTY = w_empty;
    assign bus.RAS_FULL  = w_full;
    assign bus.RAS_UFL   = r_ufl;

    // Next-PC selection and return-stack operation decode
    always_comb begin
        w_pc_next  = r_pc;
        w_epc_next = r_epc;
        w_ufl_next = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_replace  = 1'b0;
        if (bus.TRAP) begin
            w_pc_next  = TRAP_VEC;
            w_epc_next = r_pc;
        end else if (bus.EN) begin
            w_pc_next = r_pc;
        end else if (bus.RET && bus.CALL) begin
            // return into the caller and reuse its slot for the new call
            if (w_empty) begin
                w_pc_next = bus.BR_TARGET;
                w_push    = 1'b1;
            end else begin
                w_pc_next = w_top;
                w_replace = 1'b1;
            end
        end else if (bus.RET) begin
            if (w_empty) begin
                w_pc_next  = w_pc_plus;
                w_ufl_next = 1'b1;
            end else begin
                w_pc_next = w_top;
                w_pop     = 1'b1;
            end
        end else if (bus.CALL) begin
            w_pc_next = bus.BR_TARGET;
            w_push    = 1'b1;
        end else if (bus.BR_TAKEN) begin
            w_pc_next = bus.BR_TARGET;
        end else begin
            w_pc_next = w_pc_plus;
        end
    end

    // PC, EPC, underflow pulse and stack pointer/count registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc  <= RESET_VEC;
            r_epc <= '0;
            r_ufl <= 1'b0;
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_next;
            r_epc <= w_epc_next;
            r_ufl <= w_ufl_next;
            if (w_push) begin
                // a push when full overwrites the oldest slot; count saturates
                r_ptr <= r_ptr + 1'b1;
                if (!w_full) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Return-address storage; contents are meaningless while count is zero
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_push) begin
                r_ras[r_ptr] <= w_pc_plus;
            end else if (w_replace) begin
                r_ras[w_top_idx] <= w_pc_plus;
            end
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: sequential advance, stall, call/return
// nesting, stack overflow/underflow, trap priority, wrap and reset.
module tb_pc_ctrl;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    pc_ctrl_if #(.WIDTH(32)) bus_if ();

    pc_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic br, input logic [31:0] tgt,
                         input logic call, input logic ret, input logic trap);
        bus_if.EN        = en;
        bus_if.BR_TAKEN  = br;
        bus_if.BR_TARGET = tgt;
        bus_if.CALL      = call;
        bus_if.RET       = ret;
        bus_if.TRAP      = trap;
    endtask

    // one clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b en=%0b br=%0b call=%0b ret=%0b trap=%0b -> pc=0x%08h epc=0x%08h empty=%0b full=%0b ufl=%0b",
                 $time, rst, bus_if.EN, bus_if.BR_TAKEN, bus_if.CALL, bus_if.RET, bus_if.TRAP,
                 bus_if.PCOut, bus_if.EPC, bus_if.RAS_EMPTY, bus_if.RAS_FULL, bus_if.RAS_UFL);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_pc",    bus_if.PCOut, 32'h0);
        chk("rst_epc",   bus_if.EPC, 32'h0);
        chk("rst_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        chk("rst_full",  32'(bus_if.RAS_FULL), 32'd0);
        chk("rst_ufl",   32'(bus_if.RAS_UFL), 32'd0);

        // sequential advance
        rst = 1'b0;
        chk("seq0", bus_if.PCOut, 32'h0);
        chk("seq0_plus", bus_if.PCPlus, 32'h4);
        step(); chk("seq1", bus_if.PCOut, 32'h4);
        step(); chk("seq2", bus_if.PCOut, 32'h8);

        // stall with a branch presented: nothing moves, nothing queued
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall", bus_if.PCOut, 32'h8);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk("stall_release", bus_if.PCOut, 32'hC);
        chk("seq_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        step(); chk("seq4", bus_if.PCOut, 32'h10);

        // nested call/return
        drive(1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
        step(); chk("call1", bus_if.PCOut, 32'h200);
        drive(1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);
        step(); chk("call2", bus_if.PCOut, 32'h300);
        chk("call2_nonempty", 32'(bus_if.RAS_EMPTY), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(); chk("ret1", bus_if.PCOut, 32'h204);
        chk("ret1_ufl", 32'(bus_if.RAS_UFL), 32'd0);
        step(); chk("ret2", bus_if.PCOut, 32'h14);
        chk("ret2_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        chk("ret2_ufl", 32'(bus_if.RAS_UFL), 32'd0);

        // overflow: five calls from 0x000..0x400
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk("br_zero", bus_if.PCOut, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 32'(i * 32'h100), 1'b1, 1'b0, 1'b0);
            step(); chk("ovf_call", bus_if.PCOut, 32'(i * 32'h100));
            chk("ovf_full", 32'(bus_if.RAS_FULL), (i >= 4) ? 32'd1 : 32'd0);
        end
        // four returns hit the newest four pushes, fifth underflows
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            step(); chk("ovf_ret", bus_if.PCOut, 32'(i * 32'h100 + 4));
            chk("ovf_ret_ufl", 32'(bus_if.RAS_UFL), 32'd0);
        end
        chk("ovf_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        step(); chk("ufl_pc", bus_if.PCOut, 32'h108);
        chk("ufl_pulse", 32'(bus_if.RAS_UFL), 32'd1);
        chk("ufl_still_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk("ufl_clear_pc", bus_if.PCOut, 32'h10C);
        chk("ufl_clear", 32'(bus_if.RAS_UFL), 32'd0);

        // trap wins over stall/ret/branch; stack left intact
        drive(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
        step(); chk("pre_trap", bus_if.PCOut, 32'h40);
        drive(1'b1, 1'b1, 32'h999, 1'b0, 1'b1, 1'b1);
        step(); chk("trap_pc", bus_if.PCOut, 32'h80);
        chk("trap_epc", bus_if.EPC, 32'h40);
        chk("trap_ras", 32'(bus_if.RAS_EMPTY), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(); chk("post_trap_ret", bus_if.PCOut, 32'h110);
        chk("post_trap_empty", 32'(bus_if.RAS_EMPTY), 32'd1);

        // call and return together
        drive(1'b0, 1'b0, 32'h500, 1'b1, 1'b0, 1'b0);
        step(); chk("cr_call", bus_if.PCOut, 32'h500);
        drive(1'b0, 1'b0, 32'h600, 1'b1, 1'b1, 1'b0);
        step(); chk("cr_both", bus_if.PCOut, 32'h114);
        chk("cr_both_nonempty", 32'(bus_if.RAS_EMPTY), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(); chk("cr_ret", bus_if.PCOut, 32'h504);
        chk("cr_ret_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        drive(1'b0, 1'b0, 32'h700, 1'b1, 1'b1, 1'b0);
        step(); chk("cr_empty_pc", bus_if.PCOut, 32'h700);
        chk("cr_empty_ufl", 32'(bus_if.RAS_UFL), 32'd0);
        chk("cr_empty_push", 32'(bus_if.RAS_EMPTY), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(); chk("cr_empty_ret", bus_if.PCOut, 32'h508);

        // wrap-around
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        step(); chk("wrap_pre", bus_if.PCOut, 32'hFFFF_FFFC);
        chk("wrap_plus", bus_if.PCPlus, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk("wrap_pc", bus_if.PCOut, 32'h0);

        // reset mid-operation with two stack entries and a captured EPC
        drive(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0);
        step(); chk("mr_call1", bus_if.PCOut, 32'h20);
        drive(1'b0, 1'b0, 32'h30, 1'b1, 1'b0, 1'b0);
        step(); chk("mr_call2", bus_if.PCOut, 32'h30);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(); chk("mr_trap_epc", bus_if.EPC, 32'h30);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h900, 1'b1, 1'b0, 1'b0);
        step(); chk("mr_pc", bus_if.PCOut, 32'h0);
        chk("mr_empty", 32'(bus_if.RAS_EMPTY), 32'd1);
        chk("mr_epc", bus_if.EPC, 32'h0);
        chk("mr_full", 32'(bus_if.RAS_FULL), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(); chk("mr_ret_ufl", 32'(bus_if.RAS_UFL), 32'd1);
        chk("mr_ret_pc", bus_if.PCOut, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised successor to the fetch-stage program counter.
- Holds the fetch address and selects the next value each cycle from these sources, in priority order: reset vector, trap vector, hold, return address, redirect target, sequential increment.
- Contains a small circular return-address stack (RAS) for call/return, and captures the faulting PC on a trap.
- Sits between the hazard unit/branch logic and instruction memory.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VEC, 32'h00000000, PC value after reset.
- TRAP_VEC, 32'h00000080, PC value loaded on TRAP.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.

Ports:
- CLK, input, 1, rising-edge clock.
- RST, input, 1, synchronous active-high reset.
- EN, input, 1, active-low enable: 0 = PC may advance, 1 = hold (stall).
- BR_TAKEN, input, 1, redirect to BR_TARGET.
- BR_TARGET, input, WIDTH, redirect or call target.
- CALL, input, 1, jump to BR_TARGET and push PCOut+INC.
- RET, input, 1, jump to RAS top and pop.
- TRAP, input, 1, jump to TRAP_VEC and capture PCOut into EPC.
- PCOut, output, WIDTH, current fetch address (registered).
- PCPlus, output, WIDTH, PCOut+INC (combinational, modulo 2^WIDTH).
- EPC, output, WIDTH, PC captured on the last trap.
- RAS_EMPTY, output, 1, RAS holds 0 entries.
- RAS_FULL, output, 1, RAS holds RAS_DEPTH entries.
- RAS_UFL, output, 1, one-cycle pulse: RET was accepted while the RAS was empty.

Behaviour:
- All state updates occur on the rising edge of CLK. No initial blocks are used for functional reset.
- Reset (RST=1, overrides everything, including mid-stall and mid-trap):
  - PCOut=RESET_VEC, EPC=0.
  - RAS count=0, RAS pointer=0, RAS_UFL=0, so RAS_EMPTY=1 and RAS_FULL=0.
- Next-PC priority when RST=0:
  1. TRAP=1: PCOut<=TRAP_VEC and EPC<=PCOut. EN is ignored. RAS is unchanged. CALL, RET and BR_TAKEN are ignored.
  2. EN=1: PCOut, RAS and EPC are all held. CALL, RET and BR_TAKEN are ignored; none are queued.
  3. RET=1:
     - RAS non-empty: PCOut<=RAS top, count decrements.
     - RAS empty: PCOut<=PCPlus, RAS_UFL=1 for one cycle, count stays 0.
  4. CALL=1: PCOut<=BR_TARGET and push PCPlus. BR_TAKEN is don't-care.
  5. BR_TAKEN=1: PCOut<=BR_TARGET.
  6. Otherwise: PCOut<=PCPlus.
- Redirect latency: a redirect presented in cycle N appears on PCOut in cycle N+1. The PC has one cycle of latency.
- Wrap-around: PCPlus and all PC arithmetic wrap modulo 2^WIDTH. There is no overflow flag.
- RAS organisation: circular buffer with a top pointer and a saturating count in 0..RAS_DEPTH.
- Push when full: overwrites the oldest entry. The pointer advances, count stays at RAS_DEPTH, and no error is flagged.
- CALL and RET in the same accepted cycle:
  - RAS non-empty: PCOut<=RAS top, then the top entry is replaced with PCPlus. Count is unchanged.
  - RAS empty: behaves as CALL alone. RAS_UFL is not asserted.
- RAS_UFL is registered and clears the next cycle unless a new underflow occurs.
- RAS_EMPTY and RAS_FULL are derived from the registered count. They reflect the state after the last edge.

Test Plan:
- Reset and sequential advance, INC=4: assert RST for 2 cycles, release with EN=0 -> PCOut = 0x00, then 0x04, 0x08, 0x0C; RAS_EMPTY=1.
- Stall: at PCOut=0x08, hold EN=1 for 3 cycles while pulsing BR_TAKEN with BR_TARGET=0x100 -> PCOut stays 0x08 throughout. After EN=0 -> 0x0C.
- Call/return nesting, RAS_DEPTH=4:
  - Stimulus: from PC 0x10, CALL to 0x200; at 0x200, CALL to 0x300; then RET; then RET.
  - Required response: PCOut sequence 0x200, 0x300, 0x204, 0x14.
  - RAS_EMPTY=1 at the end, RAS_UFL never asserted.
- RAS overflow and underflow:
  - Stimulus: 5 CALLs from PCs 0x00, 0x100, 0x200, 0x300, 0x400, with pushes 0x04, 0x104, 0x204, 0x304, 0x404.
  - Required response: RAS_FULL=1 after the 4th push.
  - Then 5 RETs -> targets 0x404, 0x304, 0x204, 0x104; the 5th RET goes to PCPlus with a one-cycle RAS_UFL pulse.
- Trap priority: at PCOut=0x40, assert TRAP together with EN=1, RET and BR_TAKEN -> next PCOut=0x80, EPC=0x40, RAS count unchanged.
- Wrap and reset mid-operation:
  - Force PCOut=0xFFFFFFFC via BR_TARGET -> next PCOut=0x00000000.
  - With 2 RAS entries, assert RST concurrently with CALL -> PCOut=0x00, RAS_EMPTY=1, EPC=0.
